// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between 16 requesters and the round-robin arbiter.
interface rr_arbiter16_if;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_code;
    logic        gnt_valid;
    logic        timeout;

    // Requester/consumer side drives req and done, observes the grant.
    modport master (
        output req, done,
        input  gnt, gnt_code, gnt_valid, timeout
    );

    // Arbiter side.
    modport slave (
        input  req, done,
        output gnt, gnt_code, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter. One grant at a time, held until the owner drops
// its request, the consumer pulses done, or the optional MAX_HOLD timeout
// expires. One idle cycle always separates consecutive grants.
module rr_arbiter16 #(
    parameter int unsigned MAX_HOLD = 0   // 0 disables the hold timeout
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter16_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e      state_q;
    logic [15:0] gnt_q;
    logic [3:0]  code_q;
    logic        valid_q;
    logic        timeout_q;
    logic [3:0]  ptr_q;       // last granted index; scan starts just above it
    logic [15:0] hold_cnt_q;

    logic        found_d;
    logic [3:0]  idx_d;
    logic [15:0] gnt_d;
    logic        rel_done;
    logic        rel_drop;
    logic        rel_hold;
    logic        release_d;

    // 16-to-4 one-hot encoder; zero input encodes to zero.
    function automatic logic [3:0] enc16to4(input logic [15:0] oh);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) r = r | 4'(i);
        end
        return r;
    endfunction

    // Priority scan from ptr+1 upward with wrap; ptr itself is checked last.
    always_comb begin
        logic [3:0] cand;
        found_d = 1'b0;
        idx_d   = 4'd0;
        cand    = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            cand = ptr_q + 4'(k);
            if (!found_d && bus.req[cand]) begin
                found_d = 1'b1;
                idx_d   = cand;
            end
        end
        gnt_d = found_d ? (16'h0001 << idx_d) : 16'h0000;
    end

    // Release terms for the grant currently held.
    always_comb begin
        rel_done  = bus.done;
        rel_drop  = !bus.req[code_q];
        rel_hold  = (MAX_HOLD != 0) && (hold_cnt_q == 16'(MAX_HOLD - 1));
        release_d = rel_done || rel_drop || rel_hold;
    end

    // Arbiter FSM with registered grant outputs and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 16'h0000;
            code_q     <= 4'd0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            ptr_q      <= 4'hF;
            hold_cnt_q <= 16'd0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        gnt_q      <= gnt_d;
                        code_q     <= enc16to4(gnt_d);
                        valid_q    <= 1'b1;
                        hold_cnt_q <= 16'd0;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        gnt_q     <= 16'h0000;
                        code_q    <= 4'd0;
                        valid_q   <= 1'b0;
                        ptr_q     <= code_q;
                        state_q   <= IDLE;
                        // Flag only releases forced purely by the hold limit.
                        timeout_q <= rel_hold && !rel_done && !rel_drop;
                    end else if (hold_cnt_q != 16'hFFFF) begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_code  = code_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed vector table plus random invariant checks for rr_arbiter16.
module tb_rr_arbiter16;

    logic clk;
    logic rst4;
    logic rst0;

    rr_arbiter16_if bus4();
    rr_arbiter16_if bus0();

    rr_arbiter16 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
    rr_arbiter16 #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic [15:0] gnt;
        logic [3:0]  code;
        logic        vld;
        logic        to;
    } vec_t;

    vec_t tbl[$];
    int   applied;
    int   miscompares;

    task automatic add(input logic r, input logic [15:0] q, input logic d,
                       input logic [15:0] g, input logic [3:0] c,
                       input logic v, input logic t);
        vec_t e;
        e.rst = r; e.req = q; e.done = d;
        e.gnt = g; e.code = c; e.vld = v; e.to = t;
        tbl.push_back(e);
    endtask

    function automatic logic [3:0] ref_enc(input logic [15:0] oh);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) if (oh[i]) r = 4'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int          wait_cnt[16];
    logic [15:0] r;
    logic        prev_vld;
    int          pop;

    initial begin
        applied = 0;
        miscompares = 0;
        rst4 = 1'b1; rst0 = 1'b1;
        bus4.req = '0; bus4.done = 1'b0;
        bus0.req = '0; bus0.done = 1'b0;

        //   rst   req       done  gnt       code  vld   to
        add(1'b1, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0); // reset state
        add(1'b0, 16'h0001, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0); // basic grant
        add(1'b0, 16'h0001, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0); // req drop
        add(1'b1, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
        add(1'b0, 16'h8001, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0); // fairness 0
        add(1'b0, 16'h8001, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0);
        add(1'b0, 16'h8001, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0);
        add(1'b0, 16'h8001, 1'b0, 16'h8000, 4'hF, 1'b1, 1'b0); // 15
        add(1'b0, 16'h8001, 1'b0, 16'h8000, 4'hF, 1'b1, 1'b0);
        add(1'b0, 16'h8001, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0);
        add(1'b0, 16'h8001, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0); // 0
        add(1'b0, 16'h8001, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0);
        add(1'b0, 16'h8001, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0);
        add(1'b0, 16'h8001, 1'b0, 16'h8000, 4'hF, 1'b1, 1'b0); // 15
        add(1'b0, 16'h8001, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0);
        add(1'b0, 16'h0020, 1'b0, 16'h0020, 4'h5, 1'b1, 1'b0); // set ptr=5
        add(1'b0, 16'h0020, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0);
        add(1'b0, 16'h0121, 1'b0, 16'h0100, 4'h8, 1'b1, 1'b0); // from 6 -> 8
        add(1'b0, 16'h0121, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0);
        add(1'b0, 16'h0121, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0); // wrap -> 0
        add(1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
        add(1'b0, 16'h0004, 1'b0, 16'h0004, 4'h2, 1'b1, 1'b0); // hold cycle 1
        add(1'b0, 16'h0004, 1'b0, 16'h0004, 4'h2, 1'b1, 1'b0); // 2
        add(1'b0, 16'h0004, 1'b0, 16'h0004, 4'h2, 1'b1, 1'b0); // 3
        add(1'b0, 16'h0004, 1'b0, 16'h0004, 4'h2, 1'b1, 1'b0); // 4
        add(1'b0, 16'h0004, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1); // forced release
        add(1'b0, 16'h0004, 1'b0, 16'h0004, 4'h2, 1'b1, 1'b0); // re-grant
        add(1'b0, 16'h0004, 1'b0, 16'h0004, 4'h2, 1'b1, 1'b0);
        add(1'b0, 16'h0004, 1'b0, 16'h0004, 4'h2, 1'b1, 1'b0);
        add(1'b0, 16'h0004, 1'b0, 16'h0004, 4'h2, 1'b1, 1'b0);
        add(1'b0, 16'h0004, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0); // done on expiry
        add(1'b0, 16'h0200, 1'b0, 16'h0200, 4'h9, 1'b1, 1'b0); // grant 9
        add(1'b0, 16'h0201, 1'b0, 16'h0200, 4'h9, 1'b1, 1'b0); // no preempt
        add(1'b1, 16'h0201, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0); // reset mid-grant
        add(1'b0, 16'h0201, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0); // ptr back at 15
        add(1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);

        @(negedge clk);
        foreach (tbl[i]) begin
            rst4      = tbl[i].rst;
            bus4.req  = tbl[i].req;
            bus4.done = tbl[i].done;
            @(posedge clk);
            @(negedge clk);
            applied++;
            chk($sformatf("v%0d gnt", i),       32'(bus4.gnt),       32'(tbl[i].gnt));
            chk($sformatf("v%0d gnt_code", i),  32'(bus4.gnt_code),  32'(tbl[i].code));
            chk($sformatf("v%0d gnt_valid", i), 32'(bus4.gnt_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d timeout", i),   32'(bus4.timeout),   32'(tbl[i].to));
        end
        bus4.done = 1'b0;

        // MAX_HOLD=0: grant held indefinitely while requested, no timeout.
        rst0 = 1'b0;
        bus0.req = 16'h0004;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            applied++;
            chk($sformatf("nohold c%0d gnt", c), 32'(bus0.gnt),     32'h0004);
            chk($sformatf("nohold c%0d to", c),  32'(bus0.timeout), 32'h0);
        end
        bus0.done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.done = 1'b0;
        applied++;
        chk("nohold release", 32'(bus0.gnt_valid), 32'h0);

        // Random invariants on the MAX_HOLD=4 instance.
        rst4 = 1'b1;
        bus4.req = '0;
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        for (int i = 0; i < 16; i++) wait_cnt[i] = 0;
        prev_vld = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            r = 16'($urandom) | 16'($urandom);
            bus4.req  = r;
            bus4.done = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            @(negedge clk);
            applied++;
            pop = $countones(bus4.gnt);
            if (pop > 1) begin
                miscompares++;
                $display("FAIL rand c%0d onehot: gnt=%h popcount %0d required <=1", c, bus4.gnt, pop);
            end
            chk($sformatf("rand c%0d code", c),  32'(bus4.gnt_code),  32'(ref_enc(bus4.gnt)));
            chk($sformatf("rand c%0d valid", c), 32'(bus4.gnt_valid), 32'(bus4.gnt != 0));
            for (int i = 0; i < 16; i++) begin
                if (!r[i]) wait_cnt[i] = 0;
                else if (bus4.gnt_valid && !prev_vld) begin
                    if (bus4.gnt_code == 4'(i)) wait_cnt[i] = 0;
                    else wait_cnt[i]++;
                end
                if (wait_cnt[i] > 15) begin
                    miscompares++;
                    $display("FAIL rand c%0d starve req%0d: waited %0d grants, limit 15", c, i, wait_cnt[i]);
                    wait_cnt[i] = 0;
                end
            end
            prev_vld = bus4.gnt_valid;
        end
        bus4.req = '0;
        bus4.done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Round-robin arbiter for 16 requesters (key lines, interrupt sources, bus masters) sharing a single downstream resource.
- Grants one requester at a time.
- Presents the grant both as a one-hot vector and as a 4-bit index with a valid flag. The index uses the same encoding as the team's 16-to-4 one-hot encoder, with the valid flag playing the role of its enable.
- Holds each grant until the requester releases, the consumer signals done, or an optional hold timeout expires.

Parameters:
- MAX_HOLD, 0, maximum cycles a grant may be held. 0 disables the timeout. Legal range 0..65535.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  16  request lines; bit i set means requester i wants the resource.
- done  input  1  single-cycle pulse from the consumer releasing the current grant.
- gnt  output  16  one-hot grant vector; all zero when no grant is active.
- gnt_code  output  4  binary index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  single-cycle pulse on the cycle a grant is force-released by MAX_HOLD.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state is registered.
- Reset values: gnt=0, gnt_code=0, gnt_valid=0, timeout=0, state=IDLE, priority pointer ptr=15, hold counter hold_cnt=0.
  - With ptr=15, requester 0 has top priority after reset.
- Reset mid-grant: at the edge where rst=1, all outputs clear and ptr returns to 15. No done or timeout pulse is generated.
- Output consistency: gnt_code always equals the encoding of gnt. gnt has at most one bit set. gnt_valid = |gnt.
- States:
  - IDLE: no grant active.
  - GRANT: one grant held.
- IDLE:
  - On each edge with req != 0, select the first set bit scanning from (ptr+1) mod 16 upward, wrapping 15 to 0.
  - Load gnt, gnt_code and gnt_valid=1, clear hold_cnt, go to GRANT.
  - Latency: req sampled at edge N gives gnt_valid=1 visible after edge N.
  - With req=0, stay in IDLE.
  - done is ignored in IDLE.
- GRANT: let idx be the granted index.
  - Release condition, evaluated each edge: done=1, OR req[idx]=0, OR (MAX_HOLD != 0 AND hold_cnt == MAX_HOLD-1).
  - On release:
    - gnt, gnt_code and gnt_valid clear at that edge.
    - ptr <= idx; go to IDLE.
    - Exactly one idle cycle (gnt_valid=0) separates consecutive grants.
  - Otherwise hold_cnt increments. hold_cnt saturates and never wraps; it is 16 bits wide.
  - The grant is held for at most MAX_HOLD cycles with gnt_valid=1.
- timeout:
  - Registered and asserted for exactly 1 cycle, the cycle after the forced-release edge.
  - Asserted only when the timeout term alone caused the release, i.e. done=0 and req[idx]=1 on that edge.
  - When done or a req drop coincides with timeout expiry, the release is normal and no timeout pulse is generated.
- Requests from other lines while GRANT is held are not preempting; they wait for the next IDLE evaluation.
- The released requester becomes lowest priority on the next arbitration. If it is the only requester still asserting, it is re-granted after the one idle cycle.
- req is treated as level-sensitive and synchronous to clk; no internal synchronisers.

Test Plan:
- Basic grant: after reset, req=16'h0001 -> one edge later gnt=16'h0001, gnt_code=0, gnt_valid=1. Drop req -> gnt_valid=0 the next cycle.
- Round-robin fairness: req=16'h8001 held constant, done pulsed 2 cycles after each grant -> grant sequence 0, 15, 0, 15 with gnt_code 0x0, 0xF, 0x0, 0xF, and one idle cycle between grants.
- Pointer wrap: force ptr=5 via a grant/release of requester 5, then req=16'h0121 -> next grant index 8. Release -> next grant index 0 (wrap), not 5.
- Timeout, MAX_HOLD=4: req=16'h0004 held, no done -> gnt_valid high exactly 4 cycles, timeout=1 for one cycle after release, idle 1 cycle, re-grant index 2. Repeat with done coincident on the 4th cycle -> timeout stays 0.
- Reset mid-grant: grant index 9 active, assert rst for 1 cycle -> all outputs 0 after that edge. Then req=16'h0201 -> grant index 0, confirming ptr reset to 15.
- Invariants checked every cycle across 10k random cycles with random req/done: popcount(gnt) <= 1, gnt_code matches the encoding of gnt, and no requester waits more than 15 grants while continuously requesting.
